// File: rtl/mem_responder_if.sv
// Core-side bus of the memory responder: fetch port, load/store port,
// stall/halt handshake and the RAM preload port.
// master = core/preloader side, slave = mem_responder.
interface mem_responder_if #(
    parameter int WORD       = 32,
    parameter int ADDR       = 32,
    parameter int DEPTH_LOG2 = 10
);
    // instruction fetch
    logic [ADDR-1:0]       inst_addr_i;
    logic [WORD-1:0]       inst_o;
    // load/store
    logic                  ldst_valid_i;
    logic                  ldst_write_i;
    logic [ADDR-1:0]       ldst_addr_i;
    logic [WORD-1:0]       ldst_data_i;
    logic [WORD-1:0]       ldst_data_o;
    // pipeline control
    logic                  stall_o;
    logic                  hlt_i;
    logic                  halted_o;
    logic                  err_o;
    // preload
    logic                  init_we_i;
    logic [DEPTH_LOG2-1:0] init_addr_i;
    logic [WORD-1:0]       init_data_i;

    modport master (
        output inst_addr_i, ldst_valid_i, ldst_write_i, ldst_addr_i, ldst_data_i,
        output hlt_i, init_we_i, init_addr_i, init_data_i,
        input  inst_o, ldst_data_o, stall_o, halted_o, err_o
    );

    modport slave (
        input  inst_addr_i, ldst_valid_i, ldst_write_i, ldst_addr_i, ldst_data_i,
        input  hlt_i, init_we_i, init_addr_i, init_data_i,
        output inst_o, ldst_data_o, stall_o, halted_o, err_o
    );
endinterface

// File: rtl/mem_responder.sv
// Purpose: single-ported word RAM serving the core's fetch and load/store ports, one-word instruction buffer.
// Latency: MEM_LAT+1 cycles per RAM access (data access, then instruction refill if the fetch misses).
// Backpressure: stall_o is held high until the fetch hits and any pending load/store has completed.
//
// Ports: clk, reset (async, active-high), bus (mem_responder_if.slave):
//   inst_addr_i/inst_o        fetch address / buffered instruction (valid when stall_o=0)
//   ldst_*                    load/store request, held by the core until an accept cycle
//   stall_o, hlt_i, halted_o  core stall, halt request, halt acknowledge
//   err_o                     sticky out-of-range access flag
//   init_we_i/addr/data       RAM preload port
// Optional: define MEMRESP_SMC_EN to make stores update a matching instruction buffer.
module mem_responder #(
    parameter int WORD       = 32,
    parameter int ADDR       = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int MEM_LAT    = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int TAG_W = ADDR - 2;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_D_ACC = 2'd1;
    localparam logic [1:0] S_I_ACC = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [WORD-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             ibuf_v_q,    ibuf_v_d;
    logic [TAG_W-1:0] ibuf_tag_q,  ibuf_tag_d;
    logic [WORD-1:0]  inst_q,      inst_d;
    logic [WORD-1:0]  ldst_data_q, ldst_data_d;
    logic             err_q,       err_d;
    logic             d_done_q,    d_done_d;
    logic             d_write_q,   d_write_d;
    logic [TAG_W-1:0] d_tag_q,     d_tag_d;
    logic [WORD-1:0]  d_wdata_q,   d_wdata_d;

    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_widx;
    logic [WORD-1:0]       mem_wdata;

    logic                  hit;
    logic                  stall;
    logic                  d_in_range;
    logic                  f_in_range;
    logic [DEPTH_LOG2-1:0] d_idx;
    logic [DEPTH_LOG2-1:0] f_idx;

    // Byte-offset bits of both addresses are don't-care for a word RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.inst_addr_i[1:0], bus.ldst_addr_i[1:0]};

    // A word tag is in range when every bit above the RAM index is zero.
    assign d_idx      = d_tag_q[DEPTH_LOG2-1:0];
    assign f_idx      = ibuf_tag_q[DEPTH_LOG2-1:0];
    assign d_in_range = (d_tag_q    >> DEPTH_LOG2) == '0;
    assign f_in_range = (ibuf_tag_q >> DEPTH_LOG2) == '0;

    assign hit   = ibuf_v_q && (ibuf_tag_q == bus.inst_addr_i[ADDR-1:2]);
    assign stall = !((state_q == S_IDLE) && hit &&
                     (!bus.ldst_valid_i || d_done_q) && !bus.init_we_i);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ibuf_v_d    = ibuf_v_q;
        ibuf_tag_d  = ibuf_tag_q;
        inst_d      = inst_q;
        ldst_data_d = ldst_data_q;
        err_d       = err_q;
        d_done_d    = d_done_q;
        d_write_d   = d_write_q;
        d_tag_d     = d_tag_q;
        d_wdata_d   = d_wdata_q;
        mem_we      = 1'b0;
        mem_widx    = '0;
        mem_wdata   = '0;

        // The core consumes a completed load/store in any non-stalled cycle.
        if (!stall) begin
            d_done_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.init_we_i) begin
                    mem_we    = 1'b1;
                    mem_widx  = bus.init_addr_i;
                    mem_wdata = bus.init_data_i;
                end else if (bus.hlt_i) begin
                    state_d = S_HALT;
                end else if (bus.ldst_valid_i && !d_done_q) begin
                    d_write_d = bus.ldst_write_i;
                    d_tag_d   = bus.ldst_addr_i[ADDR-1:2];
                    d_wdata_d = bus.ldst_data_i;
                    cnt_d     = CNT_INIT;
                    state_d   = S_D_ACC;
                end else if (!hit) begin
                    // Buffer is invalid until the fill lands; tag is the fill address.
                    ibuf_tag_d = bus.inst_addr_i[ADDR-1:2];
                    ibuf_v_d   = 1'b0;
                    cnt_d      = CNT_INIT;
                    state_d    = S_I_ACC;
                end
            end

            S_D_ACC: begin
                if (cnt_q == '0) begin
                    if (!d_in_range) begin
                        err_d = 1'b1;
                        if (!d_write_q) begin
                            ldst_data_d = '0;
                        end
                    end else if (d_write_q) begin
                        mem_we    = 1'b1;
                        mem_widx  = d_idx;
                        mem_wdata = d_wdata_q;
`ifdef MEMRESP_SMC_EN
                        if (ibuf_v_q && (ibuf_tag_q == d_tag_q)) begin
                            inst_d = d_wdata_q;
                        end
`endif
                    end else begin
                        ldst_data_d = mem[d_idx];
                    end
                    d_done_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_I_ACC: begin
                if (cnt_q == '0) begin
                    if (f_in_range) begin
                        inst_d = mem[f_idx];
                    end else begin
                        inst_d = '0;
                        err_d  = 1'b1;
                    end
                    ibuf_v_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                // HALT: only the preloader may still touch the RAM.
                if (bus.init_we_i) begin
                    mem_we    = 1'b1;
                    mem_widx  = bus.init_addr_i;
                    mem_wdata = bus.init_data_i;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ibuf_v_q    <= 1'b0;
            ibuf_tag_q  <= '0;
            inst_q      <= '0;
            ldst_data_q <= '0;
            err_q       <= 1'b0;
            d_done_q    <= 1'b0;
            d_write_q   <= 1'b0;
            d_tag_q     <= '0;
            d_wdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ibuf_v_q    <= ibuf_v_d;
            ibuf_tag_q  <= ibuf_tag_d;
            inst_q      <= inst_d;
            ldst_data_q <= ldst_data_d;
            err_q       <= err_d;
            d_done_q    <= d_done_d;
            d_write_q   <= d_write_d;
            d_tag_q     <= d_tag_d;
            d_wdata_q   <= d_wdata_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    assign bus.inst_o      = inst_q;
    assign bus.ldst_data_o = ldst_data_q;
    assign bus.stall_o     = stall;
    assign bus.halted_o    = (state_q == S_HALT);
    assign bus.err_o       = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus randomized fetch/load/store
// traffic, each operation checked against a transaction-level model
// (shadow RAM, instruction-buffer contents, sticky error, last load value).
module tb_mem_responder;
    localparam int WORD       = 32;
    localparam int ADDR       = 32;
    localparam int DEPTH_LOG2 = 10;
    localparam int MEM_LAT    = 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if #(.WORD(WORD), .ADDR(ADDR), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

    mem_responder #(
        .WORD(WORD), .ADDR(ADDR), .DEPTH_LOG2(DEPTH_LOG2), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    logic [31:0] mdl_mem [0:DEPTH-1];
    logic        m_iv;
    logic [29:0] m_tag;
    logic [31:0] m_ival;
    logic        m_err;
    logic [31:0] m_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic in_rng(input logic [31:0] a);
        return (a >> (DEPTH_LOG2 + 2)) == 0;
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] widx(input logic [31:0] a);
        return a[DEPTH_LOG2+1:2];
    endfunction

    task automatic model_reset();
        m_iv   = 1'b0;
        m_tag  = '0;
        m_ival = '0;
        m_err  = 1'b0;
        m_last = '0;
    endtask

    task automatic idle_inputs();
        bus.ldst_valid_i = 1'b0;
        bus.ldst_write_i = 1'b0;
        bus.ldst_addr_i  = '0;
        bus.ldst_data_i  = '0;
        bus.hlt_i        = 1'b0;
        bus.init_we_i    = 1'b0;
        bus.init_addr_i  = '0;
        bus.init_data_i  = '0;
    endtask

    // Called at a falling edge; returns at a falling edge after the accept cycle.
    task automatic do_op(input logic [31:0] fa, input logic v, input logic w,
                         input logic [31:0] la, input logic [31:0] ld);
        int exp_stall;
        int n;
        exp_stall = 0;
        if (v) begin
            exp_stall += MEM_LAT + 1;
            if (in_rng(la)) begin
                if (w) begin
                    mdl_mem[widx(la)] = ld;
`ifdef MEMRESP_SMC_EN
                    if (m_iv && m_tag == la[31:2]) m_ival = ld;
`endif
                end else begin
                    m_last = mdl_mem[widx(la)];
                end
            end else begin
                m_err = 1'b1;
                if (!w) m_last = '0;
            end
        end
        if (!(m_iv && m_tag == fa[31:2])) begin
            exp_stall += MEM_LAT + 1;
            m_iv   = 1'b1;
            m_tag  = fa[31:2];
            m_ival = in_rng(fa) ? mdl_mem[widx(fa)] : 32'h0;
            if (!in_rng(fa)) m_err = 1'b1;
        end

        idle_inputs();
        bus.inst_addr_i  = fa;
        bus.ldst_valid_i = v;
        bus.ldst_write_i = w;
        bus.ldst_addr_i  = la;
        bus.ldst_data_i  = ld;
        #1;
        n = 0;
        while (bus.stall_o && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("stall_cycles", 32'(n), 32'(exp_stall));
        check("inst_o", bus.inst_o, m_ival);
        check("ldst_data_o", bus.ldst_data_o, m_last);
        check("err_o", 32'(bus.err_o), 32'(m_err));
        check("halted_o", 32'(bus.halted_o), 32'h0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_inst"},   bus.inst_o, 32'h0);
        check({tag, "_ldst"},   bus.ldst_data_o, 32'h0);
        check({tag, "_halted"}, 32'(bus.halted_o), 32'h0);
        check({tag, "_err"},    32'(bus.err_o), 32'h0);
        check({tag, "_stall"},  32'(bus.stall_o), 32'h1);
    endtask

    initial begin
        logic [31:0] fa, la, ld;
        logic v, w;

        idle_inputs();
        bus.inst_addr_i = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // release reset and preload the whole RAM while stalled
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mdl_mem[i] = $urandom;
            if (i == 0) mdl_mem[i] = 32'h11111111;
            if (i == 1) mdl_mem[i] = 32'h22222222;
            bus.init_we_i   = 1'b1;
            bus.init_addr_i = DEPTH_LOG2'(i);
            bus.init_data_i = mdl_mem[i];
            #1;
            if (i == 0) check("stall_during_init", 32'(bus.stall_o), 32'h1);
            @(negedge clk);
        end

        // fetches, store/load round trips, load with fetch miss
        do_op(32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        do_op(32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
        do_op(32'h4, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
        do_op(32'h4, 1'b1, 1'b0, 32'h40, 32'h0);
        do_op(32'h0, 1'b1, 1'b0, 32'h40, 32'h0);

        // store into the buffered instruction word
        do_op(32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
        do_op(32'h40, 1'b1, 1'b1, 32'h40, 32'h12345678);
        do_op(32'h40, 1'b0, 1'b0, 32'h0, 32'h0);

        // out-of-range load; error is sticky
        do_op(32'h40, 1'b1, 1'b0, 32'(1) << (DEPTH_LOG2 + 2), 32'h0);
        for (int i = 0; i < 10; i++) do_op(32'h40, 1'b0, 1'b0, 32'h0, 32'h0);

        // random traffic over a small working set
        for (int i = 0; i < 300; i++) begin
            fa = 32'($urandom_range(0, 7)) << 2;
            if ($urandom_range(0, 31) == 0) fa = fa | 32'h8000_0000;
            la = 32'($urandom_range(0, 7)) << 2;
            if ($urandom_range(0, 31) == 0) la = la | (32'(1) << (DEPTH_LOG2 + 2));
            v  = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            ld = $urandom;
            do_op(fa, v, w, la, ld);
        end

        // reset in the middle of a store: store must not land
        idle_inputs();
        bus.inst_addr_i  = 32'h0;
        bus.ldst_valid_i = 1'b1;
        bus.ldst_write_i = 1'b1;
        bus.ldst_addr_i  = 32'h80;
        bus.ldst_data_i  = 32'hCAFEF00D;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        do_op(32'h80, 1'b0, 1'b0, 32'h0, 32'h0);

        // halt: acknowledged, stalls forever, preload still accepted
        idle_inputs();
        bus.hlt_i = 1'b1;
        @(negedge clk);
        #1;
        check("halted_o", 32'(bus.halted_o), 32'h1);
        check("halt_stall", 32'(bus.stall_o), 32'h1);
        idle_inputs();
        bus.init_we_i   = 1'b1;
        bus.init_addr_i = DEPTH_LOG2'(5);
        bus.init_data_i = 32'hA5A5_0F0F;
        mdl_mem[5]      = 32'hA5A5_0F0F;
        @(negedge clk);
        idle_inputs();
        bus.ldst_valid_i = 1'b1;
        bus.ldst_addr_i  = 32'h8;
        repeat (5) @(negedge clk);
        #1;
        check("halt_stall_held", 32'(bus.stall_o), 32'h1);
        check("halt_held", 32'(bus.halted_o), 32'h1);
        check("halt_no_load", bus.ldst_data_o, m_last);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        do_op(32'h14, 1'b0, 1'b0, 32'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the processor core's instruction-fetch port and load/store port.
- Serves both ports from one single-ported word RAM with MEM_LAT wait states per access.
- Generates the core's stall input.
- Holds a one-word instruction buffer; the core's fetch stage sees it as a combinational instruction port.

Parameters:
- WORD, 32, instruction and data width.
- ADDR, 32, byte-address width.
- DEPTH_LOG2, 10, RAM depth in words (2^DEPTH_LOG2).
- MEM_LAT, 2, cycles per RAM access; must be >= 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- inst_addr_i  in  ADDR  core fetch address (byte; bits [1:0] ignored).
- inst_o  out  WORD  instruction at inst_addr_i; valid when stall_o=0.
- ldst_valid_i  in  1  core load/store request; held until an accept cycle.
- ldst_write_i  in  1  1=store, 0=load.
- ldst_addr_i  in  ADDR  load/store byte address.
- ldst_data_i  in  WORD  store data from core.
- ldst_data_o  out  WORD  load data; valid in the accept cycle and held afterwards.
- stall_o  out  1  to core stall_i.
- hlt_i  in  1  core halt.
- halted_o  out  1  halt acknowledged.
- err_o  out  1  sticky out-of-range access flag.
- init_we_i  in  1  preload strobe.
- init_addr_i  in  DEPTH_LOG2  preload word index.
- init_data_i  in  WORD  preload data.

Behaviour:
- Reset (async, active-high):
  - State IDLE; ibuf_v=0, ibuf_tag=0, d_done=0, cnt=0.
  - inst_o=0, ldst_data_o=0, halted_o=0, err_o=0.
  - RAM contents not reset.
- Addressing:
  - Word index = addr[DEPTH_LOG2+1:2].
  - In range iff addr[ADDR-1:DEPTH_LOG2+2]==0.
  - Out-of-range load returns 0; out-of-range store is dropped. Either sets err_o until reset.
- States:
  - IDLE: dispatch.
  - D_ACC: data access in progress.
  - I_ACC: instruction fill in progress.
  - HALT.
- Hit condition: hit = ibuf_v && ibuf_tag==inst_addr_i[ADDR-1:2].
- stall_o (combinational) = !(state==IDLE && hit && (!ldst_valid_i || d_done) && !init_we_i). It is 1 in D_ACC, I_ACC and HALT.
- Accept cycle: any cycle with stall_o=0. If d_done was set, it clears in that cycle.
- IDLE priority, highest first:
  1. init_we_i: write RAM, stay IDLE.
  2. hlt_i: go to HALT.
  3. ldst_valid_i && !d_done: latch addr/write/data, cnt=MEM_LAT-1, go to D_ACC.
  4. !hit: latch inst tag, cnt=MEM_LAT-1, go to I_ACC.
  5. Otherwise stay IDLE.
- D_ACC:
  - Decrement cnt each cycle.
  - On the cnt==0 cycle, perform the RAM write or register read data into ldst_data_o.
  - Then set d_done=1 and go to IDLE.
- I_ACC:
  - Counts the same way.
  - On the cnt==0 cycle: inst_o<=RAM word, ibuf_v=1, go to IDLE.
  - An out-of-range fetch loads 0 and sets err_o.
- inst_addr_i changing during I_ACC does not abort the fill. The next IDLE cycle re-checks hit and refetches if needed.
- Load/store round trip:
  - Minimum latency is MEM_LAT+1 cycles from the request cycle to the accept cycle, given an instruction hit.
  - A following instruction miss adds MEM_LAT+1 cycles.
- HALT: halted_o=1, stall_o=1, no RAM access until reset. init_we_i is still accepted.
- init_we_i is ignored in D_ACC and I_ACC. The preloader only drives it while stall_o=1 after reset, or in HALT.
- Reset mid-access aborts the access. A pending store is not written.

Optional Feature:
- Macro: MEMRESP_SMC_EN.
- Defined: a store whose word index equals ibuf_tag (and ibuf_v=1) also writes inst_o in the same cycle the RAM write happens. This gives self-modifying-code coherence.
- Undefined: the instruction buffer is untouched by stores. It stays stale until the fetch address changes.

Test Plan:
- Preload RAM[0]=0x11111111, RAM[1]=0x22222222. Release reset, inst_addr_i=0, MEM_LAT=2 -> stall_o=1 for 3 cycles, then inst_o=0x11111111 with stall_o=0. Change to addr 4 -> 3 stall cycles, then 0x22222222.
- Store: ldst_valid_i=1, write=1, addr=0x40, data=0xDEADBEEF with an instruction hit -> stall 3 cycles, accept on the 4th. A following load from 0x40 -> ldst_data_o=0xDEADBEEF in its accept cycle.
- Load from 0x40 while inst_addr_i misses -> D_ACC then I_ACC. stall_o is high for 6 cycles and both results are correct.
- Load from addr (1<<(DEPTH_LOG2+2)) -> ldst_data_o=0 and err_o=1, still 1 after 10 idle cycles. Reset -> err_o=0.
- Assert reset in the middle of D_ACC for a store of 0xCAFEF00D to 0x80 -> RAM[0x20] keeps its preload value and all outputs return to reset values.
- With MEMRESP_SMC_EN and inst_addr_i=0x40 hit, store 0x12345678 to 0x40 -> inst_o=0x12345678 without a refetch. Without the macro, inst_o keeps the old value.
